// File: rtl/data_mem_hs.sv
// rtl/data_mem_hs.sv - RV32 byte-addressable data memory with valid/ready handshake and LB/LH/LW/LBU/LHU/SB/SH/SW support; optional macro DMEM_MISALIGN_TRAP_EN
module data_mem_hs #(
    parameter int DEPTH_WORDS = 64,
    parameter int ADDR_W      = 8,
    parameter int LATENCY     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int MI_W   = $clog2(DEPTH_WORDS);
    localparam int IDX_W  = ADDR_W - 2;
    localparam int IDXP_W = IDX_W + 1;
    localparam logic [IDXP_W-1:0] DEPTH_LIM = IDXP_W'(DEPTH_WORDS);
    localparam logic [3:0] LAT_M1   = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
    localparam bit         ZERO_LAT = (LATENCY == 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             state;
    logic [3:0]         cnt;
    logic               cap_we;
    logic [2:0]         cap_funct3;
    logic [ADDR_W-1:0]  cap_addr;
    logic [31:0]        cap_wdata;

    logic [31:0]        mem [DEPTH_WORDS];

    logic               acc_we;
    logic [2:0]         acc_funct3;
    logic [ADDR_W-1:0]  acc_addr;
    logic [31:0]        acc_wdata;
    logic               commit;

    logic [1:0]         acc_size;
    logic [1:0]         acc_off;
    logic [MI_W-1:0]    acc_idx;
    logic               range_err;
    logic               f3_err;
    logic               mis_err;
    logic               acc_err;
    logic [3:0]         wr_be;
    logic [31:0]        wr_data;
    logic [31:0]        rd_word;
    logic [31:0]        rd_shift;
    logic [31:0]        ld_data;

    // Access fields: live inputs while idle (zero-latency commits on the accept edge), captured copy otherwise
    always_comb begin
        acc_we     = cap_we;
        acc_funct3 = cap_funct3;
        acc_addr   = cap_addr;
        acc_wdata  = cap_wdata;
        if (state == IDLE) begin
            acc_we     = req_we;
            acc_funct3 = req_funct3;
            acc_addr   = req_addr;
            acc_wdata  = req_wdata;
        end
        commit = ((state == IDLE) && req_valid && ZERO_LAT) ||
                 ((state == WAIT) && (cnt == 4'd0));
    end

    // Decode size, lane offset, error conditions and the store lane image
    always_comb begin
        acc_size  = acc_funct3[1:0];
        acc_idx   = acc_addr[MI_W+1:2];
        range_err = ({1'b0, acc_addr[ADDR_W-1:2]} >= DEPTH_LIM);
        f3_err    = acc_we ? (acc_funct3 >= 3'd3)
                           : ((acc_funct3[1:0] == 2'd3) || (acc_funct3 == 3'd6));
`ifdef DMEM_MISALIGN_TRAP_EN
        mis_err   = ((acc_size == 2'd1) && acc_addr[0]) ||
                    ((acc_size == 2'd2) && (acc_addr[1:0] != 2'd0));
        acc_off   = acc_addr[1:0];
`else
        mis_err   = 1'b0;
        acc_off   = (acc_size == 2'd2) ? 2'd0 :
                    (acc_size == 2'd1) ? {acc_addr[1], 1'b0} : acc_addr[1:0];
`endif
        acc_err   = range_err || f3_err || mis_err;

        case (acc_size)
            2'd0: begin
                wr_be   = 4'b0001 << acc_off;
                wr_data = {4{acc_wdata[7:0]}};
            end
            2'd1: begin
                wr_be   = acc_off[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{acc_wdata[15:0]}};
            end
            default: begin
                wr_be   = 4'b1111;
                wr_data = acc_wdata;
            end
        endcase
    end

    // Load path: pick the addressed lane and sign/zero-extend it
    always_comb begin
        rd_word  = mem[acc_idx];
        rd_shift = rd_word >> {acc_off, 3'b000};
        case (acc_funct3)
            3'd0:    ld_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'd1:    ld_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'd2:    ld_data = rd_word;
            3'd4:    ld_data = {24'd0, rd_shift[7:0]};
            3'd5:    ld_data = {16'd0, rd_shift[15:0]};
            default: ld_data = 32'd0;
        endcase
        if (acc_err || acc_we) begin
            ld_data = 32'd0;
        end
    end

    // Commit-edge store: only selected lanes of an error-free store; reset blocks any write
    always_ff @(posedge clk) begin
        if (rst_n && commit && acc_we && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem[acc_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Handshake FSM: IDLE accepts, WAIT counts latency, RESP holds the response until consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 32'd0;
            rsp_err    <= 1'b0;
            cap_we     <= 1'b0;
            cap_funct3 <= 3'd0;
            cap_addr   <= '0;
            cap_wdata  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cap_we     <= req_we;
                        cap_funct3 <= req_funct3;
                        cap_addr   <= req_addr;
                        cap_wdata  <= req_wdata;
                        req_ready  <= 1'b0;
                        if (ZERO_LAT) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= ld_data;
                            rsp_err   <= acc_err;
                        end else begin
                            state <= WAIT;
                            cnt   <= LAT_M1;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= ld_data;
                        rsp_err   <= acc_err;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_hs.sv
// tb/tb_data_mem_hs.sv - randomized self-checking bench for data_mem_hs against a byte-array reference model
module tb_data_mem_hs;

    localparam int LAT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        a_req_valid, a_req_ready, a_req_we;
    logic [2:0]  a_req_funct3;
    logic [8:0]  a_req_addr;
    logic [31:0] a_req_wdata;
    logic        a_rsp_valid, a_rsp_ready, a_rsp_err;
    logic [31:0] a_rsp_rdata;

    logic        b_req_valid, b_req_ready, b_req_we;
    logic [2:0]  b_req_funct3;
    logic [7:0]  b_req_addr;
    logic [31:0] b_req_wdata;
    logic        b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [31:0] b_rsp_rdata;

    int checks = 0;
    int failures = 0;

    logic [7:0] mdl [256];

    data_mem_hs #(.DEPTH_WORDS(64), .ADDR_W(9), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_funct3(a_req_funct3), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
        .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
    );

    data_mem_hs #(.DEPTH_WORDS(64), .ADDR_W(8), .LATENCY(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_funct3(b_req_funct3), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    // Reference: memory as 256 bytes, each access applied as whole bytes
    task automatic model_access(input logic we, input logic [2:0] f3, input int addr,
                                input logic [31:0] wdata,
                                output logic [31:0] exp_rdata, output logic exp_err);
        int size;
        int base;
        logic [31:0] v;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        exp_err = (addr >= 256) || (we && f3 >= 3'd3) ||
                  (!we && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7));
`ifdef DMEM_MISALIGN_TRAP_EN
        if (addr % size != 0) exp_err = 1'b1;
        base = addr;
`else
        base = addr - (addr % size);
`endif
        exp_rdata = 32'd0;
        if (!exp_err) begin
            if (we) begin
                for (int i = 0; i < size; i++) mdl[base + i] = 8'(wdata >> (8 * i));
            end else begin
                v = 32'd0;
                for (int i = 0; i < size; i++) v = v + (32'(mdl[base + i]) << (8 * i));
                if (f3 == 3'd0 && v >= 32'd128)   v = v + 32'hFFFF_FF00;
                if (f3 == 3'd1 && v >= 32'd32768) v = v + 32'hFFFF_0000;
                exp_rdata = v;
            end
        end
    endtask

    // One request on the LATENCY=2 instance; starts and ends 1ns after a rising edge with the block idle
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [8:0] addr,
                          input logic [31:0] wdata, input int hold, input bit noisy,
                          output logic [31:0] rdata, output logic err);
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          lat;
        model_access(we, f3, int'(addr), wdata, exp_rdata, exp_err);
        checks++;
        if (a_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL req_ready_idle: got %b want 1", a_req_ready);
        end
        a_req_valid = 1'b1; a_req_we = we; a_req_funct3 = f3; a_req_addr = addr; a_req_wdata = wdata;
        @(posedge clk); #1;
        if (noisy) begin
            a_req_we = 1'b1; a_req_funct3 = 3'd2;
            a_req_addr = 9'($urandom_range(0, 255)); a_req_wdata = $urandom;
        end else begin
            a_req_valid = 1'b0;
        end
        lat = 0;
        while (a_rsp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat != LAT) begin
            failures++;
            $display("FAIL latency we=%0b f3=%0d addr=%h: got %0d wait cycles want %0d", we, f3, addr, lat, LAT);
        end
        checks++;
        if (a_req_ready !== 1'b0) begin
            failures++;
            $display("FAIL req_ready_resp: got %b want 0", a_req_ready);
        end
        for (int i = 0; i <= hold; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            checks++;
            if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== exp_rdata || a_rsp_err !== exp_err) begin
                failures++;
                $display("FAIL rsp we=%0b f3=%0d addr=%h cyc=%0d: got v=%b d=%h e=%b want v=1 d=%h e=%b",
                         we, f3, addr, i, a_rsp_valid, a_rsp_rdata, a_rsp_err, exp_rdata, exp_err);
            end
        end
        rdata = a_rsp_rdata;
        err   = a_rsp_err;
        a_rsp_ready = 1'b1;
        @(posedge clk); #1;
        a_rsp_ready = 1'b0;
        a_req_valid = 1'b0;
        checks++;
        if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL rsp_consume: got v=%b rdy=%b want v=0 rdy=1", a_rsp_valid, a_req_ready);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (a_req_ready !== 1'b1 || a_rsp_valid !== 1'b0 || a_rsp_rdata !== 32'd0 || a_rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_a: got rdy=%b v=%b d=%h e=%b want 1 0 0 0", a_req_ready, a_rsp_valid, a_rsp_rdata, a_rsp_err);
        end
        checks++;
        if (b_req_ready !== 1'b1 || b_rsp_valid !== 1'b0 || b_rsp_rdata !== 32'd0 || b_rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_b: got rdy=%b v=%b d=%h e=%b want 1 0 0 0", b_req_ready, b_rsp_valid, b_rsp_rdata, b_rsp_err);
        end
    endtask

    task automatic test_fill();
        logic [31:0] d;
        logic        e;
        for (int w = 0; w < 64; w++) do_req(1'b1, 3'd2, 9'(w * 4), $urandom, 0, 1'b0, d, e);
    endtask

    task automatic test_latency_handshake();
        logic [31:0] d;
        logic        e;
        do_req(1'b1, 3'd2, 9'h08, 32'hDEADBEEF, 0, 1'b0, d, e);
        do_req(1'b0, 3'd2, 9'h08, 32'h0, 5, 1'b0, d, e);
        checks++;
        if (d !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL lw_deadbeef: got %h want deadbeef", d);
        end
    endtask

    task automatic test_subword();
        logic [31:0] d;
        logic        e;
        logic [2:0]  f3s [5] = '{3'd2, 3'd0, 3'd4, 3'd1, 3'd5};
        logic [8:0]  ads [5] = '{9'h20, 9'h21, 9'h21, 9'h22, 9'h22};
        logic [31:0] exps[5] = '{32'hF00D8000, 32'hFFFFFF80, 32'h00000080, 32'hFFFFF00D, 32'h0000F00D};
        do_req(1'b1, 3'd2, 9'h20, 32'h00000000, 0, 1'b0, d, e);
        do_req(1'b1, 3'd0, 9'h21, 32'hABCDEF80, 0, 1'b0, d, e);
        do_req(1'b1, 3'd1, 9'h22, 32'h5555F00D, 0, 1'b0, d, e);
        for (int i = 0; i < 5; i++) begin
            do_req(1'b0, f3s[i], ads[i], 32'h0, 0, 1'b0, d, e);
            checks++;
            if (d !== exps[i] || e !== 1'b0) begin
                failures++;
                $display("FAIL subword f3=%0d addr=%h: got %h err=%b want %h err=0", f3s[i], ads[i], d, e, exps[i]);
            end
        end
    endtask

    task automatic test_errors();
        logic [31:0] d;
        logic        e;
        do_req(1'b0, 3'd2, 9'h100, 32'h0, 0, 1'b0, d, e);
        checks++;
        if (e !== 1'b1 || d !== 32'd0) begin
            failures++;
            $display("FAIL range_err: got err=%b d=%h want err=1 d=0", e, d);
        end
        do_req(1'b0, 3'd3, 9'h04, 32'h0, 0, 1'b0, d, e);
        checks++;
        if (e !== 1'b1 || d !== 32'd0) begin
            failures++;
            $display("FAIL load_f3_err: got err=%b d=%h want err=1 d=0", e, d);
        end
        do_req(1'b1, 3'd4, 9'h40, 32'h13579BDF, 0, 1'b0, d, e);
        checks++;
        if (e !== 1'b1) begin
            failures++;
            $display("FAIL store_f3_err: got err=%b want 1", e);
        end
        do_req(1'b0, 3'd2, 9'h40, 32'h0, 0, 1'b0, d, e);
    endtask

    task automatic test_misalign();
        logic [31:0] d;
        logic        e;
        do_req(1'b1, 3'd2, 9'h30, 32'hAABBCCDD, 0, 1'b0, d, e);
        do_req(1'b0, 3'd2, 9'h31, 32'h0, 0, 1'b0, d, e);
        checks++;
`ifdef DMEM_MISALIGN_TRAP_EN
        if (e !== 1'b1 || d !== 32'd0) begin
            failures++;
            $display("FAIL misalign_trap: got err=%b d=%h want err=1 d=0", e, d);
        end
`else
        if (e !== 1'b0 || d !== 32'hAABBCCDD) begin
            failures++;
            $display("FAIL misalign_force: got err=%b d=%h want err=0 d=aabbccdd", e, d);
        end
`endif
    endtask

    task automatic test_reset_wait();
        logic [31:0] d;
        logic        e;
        do_req(1'b1, 3'd2, 9'h10, 32'h0, 0, 1'b0, d, e);
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_funct3 = 3'd2; a_req_addr = 9'h10; a_req_wdata = 32'h12345678;
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (a_req_ready !== 1'b1 || a_rsp_valid !== 1'b0 || a_rsp_rdata !== 32'd0 || a_rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_wait: got rdy=%b v=%b d=%h e=%b want 1 0 0 0", a_req_ready, a_rsp_valid, a_rsp_rdata, a_rsp_err);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        do_req(1'b0, 3'd2, 9'h10, 32'h0, 0, 1'b0, d, e);
        checks++;
        if (d === 32'h12345678) begin
            failures++;
            $display("FAIL aborted_store: got %h want not 12345678", d);
        end
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic        e;
        logic [8:0]  addr;
        for (int n = 0; n < 150; n++) begin
            addr = ($urandom_range(0, 9) == 0) ? 9'($urandom_range(256, 511)) : 9'($urandom_range(0, 255));
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), addr, $urandom,
                   $urandom_range(0, 2), 1'($urandom_range(0, 1)), d, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] val;
        int          resp;
        val = $urandom;
        resp = 0;
        b_req_we = 1'b1; b_req_funct3 = 3'd2; b_req_addr = 8'h14; b_req_wdata = val;
        b_req_valid = 1'b1; b_rsp_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            checks++;
            if (b_rsp_valid !== (k % 2 == 0) || b_req_ready !== (k % 2 == 1)) begin
                failures++;
                $display("FAIL b2b_cycle%0d: got v=%b rdy=%b want v=%b rdy=%b", k, b_rsp_valid, b_req_ready, k % 2 == 0, k % 2 == 1);
            end
            if (b_rsp_valid === 1'b1) begin
                resp++;
                if (k > 0) begin
                    checks++;
                    if (b_rsp_rdata !== val || b_rsp_err !== 1'b0) begin
                        failures++;
                        $display("FAIL b2b_load%0d: got %h err=%b want %h err=0", k, b_rsp_rdata, b_rsp_err, val);
                    end
                end
            end
            if (k == 0) b_req_we = 1'b0;
            if (k == 8) b_req_valid = 1'b0;
        end
        b_rsp_ready = 1'b0;
        checks++;
        if (resp != 5) begin
            failures++;
            $display("FAIL b2b_count: got %0d responses want 5", resp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a_req_valid = 1'b0; a_req_we = 1'b0; a_req_funct3 = 3'd0; a_req_addr = '0; a_req_wdata = 32'd0; a_rsp_ready = 1'b0;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_funct3 = 3'd0; b_req_addr = '0; b_req_wdata = 32'd0; b_rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_fill();
        test_latency_handshake();
        test_subword();
        test_errors();
        test_misalign();
        test_reset_wait();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
